// File: rtl/dff_arb_pkg.sv
// Shared types and default sizing for the round-robin register-bank arbiter.
package dff_arb_pkg;

    // Arbiter FSM encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit starting at ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit to ptr wins last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        sum  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDXW + 1)'(k);
            if (sum >= (IDXW + 1)'(NREQ))
                sum = sum - (IDXW + 1)'(NREQ);
            cand = sum[IDXW-1:0];
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters take turns writing one shared register.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [IDXW-1:0]       owner,
    output logic                  wr_done,
    output logic                  busy,
    output logic [WIDTH-1:0]      Q
);

    state_e          state_q, state_d;
    logic [IDXW-1:0] owner_q, ptr_q;
    logic [WIDTH-1:0] q_q;
    logic            pick_any;
    logic [IDXW-1:0] pick_idx;
    logic [WIDTH-1:0] slice [NREQ];

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Unpack the flat write bus into per-requester slices.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            slice[i] = wdata[i*WIDTH +: WIDTH];
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: GRANT and RELEASE each last exactly one cycle.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = pick_any ? GRANT : IDLE;
            GRANT:   state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded purely from registered state so req never reaches gnt directly.
    always_comb begin
        gnt     = '0;
        wr_done = (state_q == RELEASE);
        busy    = (state_q != IDLE);
        if (state_q == GRANT)
            gnt[owner_q] = 1'b1;
    end

    // Datapath: latch winner in IDLE, commit data at GRANT close, rotate priority in RELEASE.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            owner_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
        end else begin
            if (state_q == IDLE && pick_any)
                owner_q <= pick_idx;
            if (state_q == GRANT)
                q_q <= slice[owner_q];
            if (state_q == RELEASE)
                ptr_q <= (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    assign owner = owner_q;
    assign Q     = q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8).
module tb_dff_bank_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        wr_done;
    logic        busy;
    logic [7:0]  Q;

    int checks = 0;
    int errors = 0;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .wr_done (wr_done),
        .busy    (busy),
        .Q       (Q)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From IDLE with req already presented: one full GRANT/RELEASE round.
    task automatic do_grant(input string tag, input logic [1:0] exp_owner, input logic [7:0] exp_q);
        logic [3:0] oh;
        oh = 4'b0001 << exp_owner;
        tick();
        check({tag, " gnt"}, 32'(gnt), 32'(oh));
        check({tag, " owner"}, 32'(owner), 32'(exp_owner));
        check({tag, " busy_g"}, 32'(busy), 32'd1);
        check({tag, " wr_done_g"}, 32'(wr_done), 32'd0);
        tick();
        check({tag, " Q"}, 32'(Q), 32'(exp_q));
        check({tag, " wr_done"}, 32'(wr_done), 32'd1);
        check({tag, " gnt_r"}, 32'(gnt), 32'd0);
        check({tag, " busy_r"}, 32'(busy), 32'd1);
        tick();
        check({tag, " busy_i"}, 32'(busy), 32'd0);
        check({tag, " wr_done_i"}, 32'(wr_done), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        wdata = 32'h0;

        // Reset, then idle with no requests.
        repeat (2) tick();
        check("rst Q", 32'(Q), 32'h0);
        check("rst gnt", 32'(gnt), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst wr_done", 32'(wr_done), 32'h0);
        check("rst owner", 32'(owner), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle busy", 32'(busy), 32'h0);
            check("idle wr_done", 32'(wr_done), 32'h0);
            check("idle gnt", 32'(gnt), 32'h0);
            check("idle Q", 32'(Q), 32'h0);
        end

        // Single requester 2 -> Q=A5, ptr becomes 3.
        wdata[16 +: 8] = 8'hA5;
        req = 4'b0100;
        do_grant("single", 2'd2, 8'hA5);
        req = 4'b0000;

        // Q holds between grants.
        repeat (3) begin
            tick();
            check("hold Q", 32'(Q), 32'hA5);
            check("hold gnt", 32'(gnt), 32'h0);
        end

        // ptr=3: requester 3 wins, wrap to ptr=0 so 0 wins, then 3 again.
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1001;
        do_grant("wrap3a", 2'd3, 8'h44);
        do_grant("wrap0", 2'd0, 8'h11);
        do_grant("wrap3b", 2'd3, 8'h44);

        // All four requesting from ptr=0: order 0,1,2,3,0.
        req = 4'b1111;
        do_grant("all0", 2'd0, 8'h11);
        do_grant("all1", 2'd1, 8'h22);
        do_grant("all2", 2'd2, 8'h33);
        do_grant("all3", 2'd3, 8'h44);
        do_grant("all0b", 2'd0, 8'h11);
        req = 4'b0000;

        // ptr=1: request withdrawn during GRANT still commits.
        wdata[8 +: 8] = 8'h3C;
        req = 4'b0010;
        tick();
        check("wd gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick();
        check("wd Q", 32'(Q), 32'h3C);
        check("wd wr_done", 32'(wr_done), 32'h1);
        tick();
        check("wd idle", 32'(busy), 32'h0);

        // ptr=2: requester 0 writes 77, leaving ptr=1.
        wdata[0 +: 8] = 8'h77;
        req = 4'b0001;
        do_grant("pre77", 2'd0, 8'h77);

        // Grant requester 1, then reset in the GRANT cycle.
        wdata[8 +: 8] = 8'h55;
        req = 4'b0010;
        tick();
        check("mid gnt", 32'(gnt), 32'b0010);
        check("mid owner", 32'(owner), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid rst Q", 32'(Q), 32'h0);
        check("mid rst gnt", 32'(gnt), 32'h0);
        check("mid rst busy", 32'(busy), 32'h0);
        check("mid rst wr_done", 32'(wr_done), 32'h0);
        req = 4'b0011;
        tick();
        check("in rst wr_done", 32'(wr_done), 32'h0);
        check("in rst Q", 32'(Q), 32'h0);
        reset = 1'b1;

        // ptr restarted at 0, so requester 0 beats requester 1.
        do_grant("post rst", 2'd0, 8'h77);
        req = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
